// File: rtl/tmds_deserializer.sv
// One-channel TMDS receive aligner: assembles 10-bit characters from a 2-bit DDR
// stream and slides the character window until control tokens recur.
module tmds_deserializer #(
  parameter int SEARCH_WORDS = 16,
  parameter int LOCK_TOKENS  = 8,
  parameter int LOSS_WORDS   = 4096
) (
  input  logic       clk_pixel_x5,
  input  logic       reset,
  input  logic [1:0] serial_in,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       ctrl_valid,
  output logic [1:0] ctrl,
  output logic       aligned,
  output logic [3:0] slip_offset
);

  localparam int MISS_W = $clog2(SEARCH_WORDS) + 1;
  localparam int TOK_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int LOSS_W = $clog2(LOSS_WORDS) + 1;

  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(SEARCH_WORDS - 1);
  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WORDS - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // The two oldest bits of the 20-bit history are shifted out before any
  // window can reach them, so only [19:2] is stored.
  logic [19:2]       history;
  logic [19:0]       next_history;
  logic [2:0]        phase;
  logic [9:0]        window;
  logic              win_match;
  logic [1:0]        win_ctrl;
  state_t            state;
  logic [MISS_W-1:0] miss_cnt;
  logic [TOK_W-1:0]  tok_cnt;
  logic [LOSS_W-1:0] loss_cnt;

  assign next_history = {serial_in[1], serial_in[0], history};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    window    = '0;
    win_match = 1'b0;
    win_ctrl  = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (slip_offset == 4'(i)) window = next_history[i +: 10];
    end
    case (window)
      10'h354: begin win_match = 1'b1; win_ctrl = 2'b00; end
      10'h0AB: begin win_match = 1'b1; win_ctrl = 2'b01; end
      10'h154: begin win_match = 1'b1; win_ctrl = 2'b10; end
      10'h2AB: begin win_match = 1'b1; win_ctrl = 2'b11; end
      default: begin win_match = 1'b0; win_ctrl = 2'b00; end
    endcase
  end

  always_ff @(posedge clk_pixel_x5 or posedge reset) begin
    if (reset) begin
      history    <= '0;
      phase      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      ctrl_valid <= 1'b0;
      ctrl       <= 2'b00;
    end else begin
      // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
      history    <= next_history[19:2];
      phase      <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
      word_valid <= (phase == 3'd4);
      ctrl_valid <= 1'b0;
      if (phase == 3'd4) begin
        word       <= window;
        ctrl_valid <= win_match;
        if (win_match) ctrl <= win_ctrl;
      end
    end
  end

  // Alignment FSM consumes each captured word during its word_valid cycle, so a
  // new slip_offset is first used by the following capture.
  always_ff @(posedge clk_pixel_x5 or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      miss_cnt    <= '0;
      tok_cnt     <= '0;
      loss_cnt    <= '0;
      aligned     <= 1'b0;
      slip_offset <= '0;
    end else if (word_valid) begin
      case (state)
        SEARCH: begin
          if (ctrl_valid) begin
            miss_cnt <= '0;
            if (LOCK_TOKENS <= 1) begin
              state    <= LOCKED;
              aligned  <= 1'b1;
              tok_cnt  <= '0;
              loss_cnt <= '0;
            end else begin
              state   <= VERIFY;
              tok_cnt <= TOK_W'(1);
            end
          end else if (miss_cnt >= MISS_LAST) begin
            miss_cnt    <= '0;
            slip_offset <= (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
          end else begin
            miss_cnt <= miss_cnt + MISS_W'(1);
          end
        end
        VERIFY: begin
          if (!ctrl_valid) begin
            state    <= SEARCH;
            miss_cnt <= '0;
            tok_cnt  <= '0;
          end else if (tok_cnt >= TOK_LAST) begin
            state    <= LOCKED;
            aligned  <= 1'b1;
            tok_cnt  <= '0;
            loss_cnt <= '0;
          end else begin
            tok_cnt <= tok_cnt + TOK_W'(1);
          end
        end
        LOCKED: begin
          if (ctrl_valid) begin
            loss_cnt <= '0;
          end else if (loss_cnt >= LOSS_LAST) begin
            state    <= SEARCH;
            aligned  <= 1'b0;
            loss_cnt <= '0;
            miss_cnt <= '0;
          end else begin
            loss_cnt <= loss_cnt + LOSS_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
